// File: rtl/pairhmm_array_scheduler.sv
// pairhmm_array_scheduler: dispatches Pair-HMM jobs (one read/haplotype pair
// each) onto a bank of systolic arrays and retires results in acceptance order.
// Optional per-array RUN watchdog: define SCHED_TIMEOUT_EN.
module pairhmm_array_scheduler #(
  parameter int NUM_ARRAYS  = 4,
  parameter int JOB_ID_W    = 8,
  parameter int LEN_W       = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        job_valid_i,
  output logic                        job_ready_o,
  input  logic [JOB_ID_W-1:0]         job_id_i,
  input  logic [LEN_W-1:0]            job_x_len_i,
  input  logic [LEN_W-1:0]            job_y_len_i,
  output logic [NUM_ARRAYS-1:0]       arr_reset_o,
  output logic [NUM_ARRAYS*LEN_W-1:0] arr_x_len_o,
  output logic [NUM_ARRAYS*LEN_W-1:0] arr_y_len_o,
  input  logic [NUM_ARRAYS-1:0]       arr_complete_i,
  input  logic [NUM_ARRAYS*64-1:0]    arr_final_val_i,
  output logic [NUM_ARRAYS-1:0]       arr_busy_o,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [JOB_ID_W-1:0]         res_id_o,
  output logic [63:0]                 res_val_o,
  output logic                        res_err_o
);
  localparam int IDX_W = (NUM_ARRAYS > 1) ? $clog2(NUM_ARRAYS) : 1;
  localparam int QD    = 2 * NUM_ARRAYS;
  localparam int PTR_W = $clog2(QD);
  localparam int CNT_W = $clog2(QD + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR1, S_CLR2, S_RUN, S_DONE} st_e;
  typedef struct packed {
    logic                zero;
    logic [IDX_W-1:0]    idx;
    logic [JOB_ID_W-1:0] id;
  } ent_t;

  st_e                            st_q   [NUM_ARRAYS];
  st_e                            st_d   [NUM_ARRAYS];
  logic [63:0]                    slot_q [NUM_ARRAYS];
  logic [63:0]                    slot_d [NUM_ARRAYS];
  logic                           err_q  [NUM_ARRAYS];
  logic                           err_d  [NUM_ARRAYS];
  logic [NUM_ARRAYS-1:0]          rst_q, busy_q, to_hit;
  logic [NUM_ARRAYS-1:0][LEN_W-1:0] xlen_q, ylen_q;

  ent_t                           mem_q [QD];
  ent_t                           push_ent, head_q, head_n;
  logic [PTR_W-1:0]               rd_q, rd_d, wr_q;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [IDX_W-1:0]               rr_q, pick;
  logic                           any_idle, job_zero, full, acc, acc_norm, pop, rdy_n;

  logic                           res_valid_q;
  logic [JOB_ID_W-1:0]            res_id_q;
  logic [63:0]                    res_val_q;
  logic                           res_err_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QD - 1)) ? '0 : p + 1'b1;
  endfunction

  assign arr_reset_o = rst_q;
  assign arr_busy_o  = busy_q;
  assign arr_x_len_o = xlen_q;
  assign arr_y_len_o = ylen_q;
  assign res_valid_o = res_valid_q;
  assign res_id_o    = res_id_q;
  assign res_val_o   = res_val_q;
  assign res_err_o   = res_err_q;

  // Handshake: ready depends only on registered state plus the offered lengths.
  assign job_zero    = (job_x_len_i == '0) || (job_y_len_i == '0);
  assign full        = (cnt_q == CNT_W'(QD));
  assign job_ready_o = reset_n_i && (any_idle || job_zero) && !full;
  assign acc         = job_valid_i && job_ready_o;
  assign acc_norm    = acc && !job_zero;
  assign pop         = res_valid_q && res_ready_i;
  assign head_q      = mem_q[rd_q];
  assign push_ent    = '{zero: job_zero, idx: (job_zero ? '0 : pick), id: job_id_i};

  // Round-robin search: first IDLE array at or after the rr pointer.
  always_comb begin
    any_idle = 1'b0;
    pick     = rr_q;
    for (int k = NUM_ARRAYS - 1; k >= 0; k--) begin
      if (st_q[(int'(rr_q) + k) % NUM_ARRAYS] == S_IDLE) begin
        any_idle = 1'b1;
        pick     = IDX_W'((int'(rr_q) + k) % NUM_ARRAYS);
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  logic [15:0] tcnt_q [NUM_ARRAYS];

  // Watchdog: count RUN cycles, restarted while the array is in CLR2.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < NUM_ARRAYS; i++) tcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ARRAYS; i++) begin
        if (st_q[i] == S_CLR2)     tcnt_q[i] <= '0;
        else if (st_q[i] == S_RUN) tcnt_q[i] <= tcnt_q[i] + 16'd1;
      end
    end
  end

  // Last permitted RUN cycle reached.
  always_comb begin
    for (int i = 0; i < NUM_ARRAYS; i++) to_hit[i] = (tcnt_q[i] == 16'(TIMEOUT_CYC - 1));
  end
`else
  assign to_hit = '0;
`endif

  // Per-array next state; a DONE array is only released when its own entry retires.
  always_comb begin
    for (int i = 0; i < NUM_ARRAYS; i++) begin
      st_d[i]   = st_q[i];
      slot_d[i] = slot_q[i];
      err_d[i]  = err_q[i];
      case (st_q[i])
        S_IDLE: if (acc_norm && pick == IDX_W'(i)) st_d[i] = S_CLR1;
        S_CLR1: st_d[i] = S_CLR2;
        S_CLR2: st_d[i] = S_RUN;
        S_RUN: begin
          if (arr_complete_i[i]) begin
            st_d[i]   = S_DONE;
            slot_d[i] = arr_final_val_i[i*64 +: 64];
            err_d[i]  = 1'b0;
          end else if (to_hit[i]) begin
            st_d[i]   = S_DONE;
            slot_d[i] = 64'h0;
            err_d[i]  = 1'b1;
          end
        end
        S_DONE: if (pop && !head_q.zero && head_q.idx == IDX_W'(i)) st_d[i] = S_IDLE;
        default: st_d[i] = S_IDLE;
      endcase
    end
  end

  // Next head of the order queue; a push into an empty queue becomes the head at once.
  always_comb begin
    rd_d   = pop ? ptr_inc(rd_q) : rd_q;
    cnt_d  = cnt_q + CNT_W'(acc) - CNT_W'(pop);
    head_n = (acc && wr_q == rd_d) ? push_ent : mem_q[rd_d];
    rdy_n  = (cnt_d != '0) && (head_n.zero || st_d[head_n.idx] == S_DONE);
  end

  // Array FSMs, captured results and registered array-side outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < NUM_ARRAYS; i++) begin
        st_q[i]   <= S_IDLE;
        slot_q[i] <= '0;
        err_q[i]  <= 1'b0;
      end
      rst_q  <= '1;
      busy_q <= '0;
      xlen_q <= '0;
      ylen_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ARRAYS; i++) begin
        st_q[i]   <= st_d[i];
        slot_q[i] <= slot_d[i];
        err_q[i]  <= err_d[i];
        rst_q[i]  <= (st_d[i] != S_RUN);
        busy_q[i] <= (st_d[i] != S_IDLE);
        if (st_q[i] == S_IDLE && st_d[i] == S_CLR1) begin
          xlen_q[i] <= job_x_len_i;
          ylen_q[i] <= job_y_len_i;
        end
      end
    end
  end

  // Order queue and round-robin pointer.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int q = 0; q < QD; q++) mem_q[q] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      rr_q  <= '0;
    end else begin
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (acc) begin
        mem_q[wr_q] <= push_ent;
        wr_q        <= ptr_inc(wr_q);
      end
      if (acc_norm) rr_q <= (pick == IDX_W'(NUM_ARRAYS - 1)) ? '0 : pick + 1'b1;
    end
  end

  // Result port reflects the next head, so it holds steady while stalled.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_val_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      res_valid_q <= rdy_n;
      res_id_q    <= rdy_n ? head_n.id : '0;
      res_val_q   <= (rdy_n && !head_n.zero) ? slot_d[head_n.idx] : 64'h0;
      res_err_q   <= rdy_n && (head_n.zero || err_d[head_n.idx]);
    end
  end

endmodule

// File: tb/tb_pairhmm_array_scheduler.sv
// Bench for pairhmm_array_scheduler: behavioural array responders, an in-order
// scoreboard, a job table and hand sequences for stall, reset and timeout.
module tb_pairhmm_array_scheduler;
  localparam int N  = 4;
  localparam int IW = 8;
  localparam int LW = 8;
`ifdef SCHED_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              job_valid = 1'b0, job_ready;
  logic [IW-1:0]     job_id = '0;
  logic [LW-1:0]     job_x = '0, job_y = '0;
  logic [N-1:0]      arr_reset, arr_busy;
  logic [N*LW-1:0]   arr_x_len, arr_y_len;
  logic [N-1:0]      arr_complete = '0;
  logic [N*64-1:0]   arr_final_val = '0;
  logic              res_valid, res_ready = 1'b1, res_err;
  logic [IW-1:0]     res_id;
  logic [63:0]       res_val;

  pairhmm_array_scheduler #(.NUM_ARRAYS(N), .JOB_ID_W(IW), .LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .job_valid_i(job_valid), .job_ready_o(job_ready),
    .job_id_i(job_id), .job_x_len_i(job_x), .job_y_len_i(job_y),
    .arr_reset_o(arr_reset), .arr_x_len_o(arr_x_len), .arr_y_len_o(arr_y_len),
    .arr_complete_i(arr_complete), .arr_final_val_i(arr_final_val), .arr_busy_o(arr_busy),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_id_o(res_id),
    .res_val_o(res_val), .res_err_o(res_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [IW-1:0] id; logic [63:0] val; logic err; } exp_t;
  exp_t sbq[$];
  int   n_chk = 0, n_pass = 0;
  int   pop_cyc[int];

  // Array result model: a recognisable function of the lengths the array was given.
  function automatic logic [63:0] fval(input logic [7:0] x, input logic [7:0] y);
    return 64'h3FE0_0000_0000_0000 | {48'h0, x ^ 8'h08, y ^ 8'h04};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Responders: count RUN cycles after arr_reset drops; pulse complete at lat (0 = never).
  int lat[N], cur_lat[N], rcnt[N];
  int run_starts = 0, last_run_cyc = 0;
  initial begin
    for (int i = 0; i < N; i++) begin lat[i] = 5; cur_lat[i] = 0; rcnt[i] = 0; end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (arr_reset[i]) begin
          rcnt[i] = 0;
          arr_complete[i] = 1'b0;
        end else begin
          if (rcnt[i] == 0) begin run_starts++; cur_lat[i] = lat[i]; last_run_cyc = cyc; end
          rcnt[i]++;
          arr_complete[i] = (cur_lat[i] != 0) && (rcnt[i] == cur_lat[i]);
          arr_final_val[i*64 +: 64] = fval(arr_x_len[i*LW +: LW], arr_y_len[i*LW +: LW]);
        end
      end
    end
  end

  // Scoreboard: every retirement handshake must match the oldest accepted job.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      pop_cyc[int'(res_id)] = cyc;
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL res_unexpected: got id %0h, expected no result", res_id);
      end else begin
        mon_e = sbq.pop_front();
        chk("res_id", 64'(res_id), 64'(mon_e.id));
        chk("res_val", res_val, mon_e.val);
        chk("res_err", 64'(res_err), 64'(mon_e.err));
      end
    end
  end

  task automatic send(input logic [7:0] id, input logic [7:0] x, input logic [7:0] y,
                      input bit to_exp, output int acc_cyc);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    acc_cyc = -1;
    job_valid = 1'b1; job_id = id; job_x = x; job_y = y;
    for (int b = 0; b < 400 && !ok; b++) begin
      @(negedge clk);
      if (job_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
        e.id  = id;
        e.err = to_exp || x == 0 || y == 0;
        e.val = e.err ? 64'h0 : fval(x, y);
        sbq.push_back(e);
      end
      tick();
    end
    job_valid = 1'b0;
    if (!ok) begin n_chk++; $display("FAIL send_%0h: job_ready not seen in 400 cycles, expected accept", id); end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sbq.size() != 0 && b < 1000) begin @(negedge clk); b++; end
    n_chk++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL drain: %0d results outstanding, expected 0", sbq.size());
    tick();
  endtask

  task automatic do_reset();
    tick(); rst_n = 1'b0; sbq.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct { logic [7:0] id, x, y; int arr, lat; } vec_t;
  vec_t tab[4];

  initial begin
    int a, a5, rs0, stale, b;
    bit seen;
    #2000000;
    $display("FAIL watchdog: simulation time limit hit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a5, rs0, stale, b;
    bit seen;
    // Reset state, with a zero-length job offered so job_ready gating is exercised.
    job_valid = 1'b1; job_x = 8'd0; job_y = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_job_ready", 64'(job_ready), 64'h0);
    chk("rst_arr_reset", 64'(arr_reset), 64'hF);
    chk("rst_arr_busy", 64'(arr_busy), 64'h0);
    chk("rst_x_len", 64'(arr_x_len), 64'h0);
    chk("rst_res_valid", 64'(res_valid), 64'h0);
    chk("rst_res_val", res_val, 64'h0);
    chk("rst_res_id_err", 64'({res_id, res_err}), 64'h0);
    job_valid = 1'b0;
    tick(); rst_n = 1'b1; tick();

    // Single job on array 0: reset low from the third cycle after accept until complete.
    lat[0] = 5;
    send(8'h11, 8'd8, 8'd4, 1'b0, a);
    @(negedge clk);
    chk("t1_clr1_reset", 64'(arr_reset[0]), 64'h1);
    chk("t1_x_len", 64'(arr_x_len[0 +: LW]), 64'd8);
    chk("t1_y_len", 64'(arr_y_len[0 +: LW]), 64'd4);
    chk("t1_busy", 64'(arr_busy), 64'h1);
    @(negedge clk);
    chk("t1_clr2_reset", 64'(arr_reset[0]), 64'h1);
    @(negedge clk);
    chk("t1_run_reset", 64'(arr_reset[0]), 64'h0);
    seen = 1'b0;
    for (b = 0; b < 100 && !seen; b++) begin
      @(negedge clk);
      if (arr_complete[0]) seen = 1'b1;
      else if (arr_reset[0]) begin n_chk++; $display("FAIL t1_reset_early: arr_reset 1, expected 0 until complete"); end
    end
    chk("t1_complete_seen", 64'(seen), 64'h1);
    chk("t1_valid_before", 64'(res_valid), 64'h0);
    @(negedge clk);
    chk("t1_valid_after", 64'(res_valid), 64'h1);
    chk("t1_res_val", res_val, 64'h3FE0_0000_0000_0000);
    drain();

    // Four back-to-back jobs completing in reverse order, then a fifth while all are busy.
    do_reset();
    pop_cyc.delete();
    tab[0] = '{8'd1, 8'd10, 8'd3, 0, 60};
    tab[1] = '{8'd2, 8'd11, 8'd3, 1, 50};
    tab[2] = '{8'd3, 8'd12, 8'd3, 2, 40};
    tab[3] = '{8'd4, 8'd13, 8'd3, 3, 30};
    for (int j = 0; j < 4; j++) begin
      lat[tab[j].arr] = tab[j].lat;
      send(tab[j].id, tab[j].x, tab[j].y, 1'b0, a);
      chk($sformatf("t2_arr_x_%0d", j), 64'(arr_x_len[tab[j].arr*LW +: LW]), 64'(tab[j].x));
      chk($sformatf("t2_arr_y_%0d", j), 64'(arr_y_len[tab[j].arr*LW +: LW]), 64'(tab[j].y));
    end
    chk("t2_all_busy", 64'(arr_busy), 64'hF);
    send(8'd5, 8'd3, 8'd3, 1'b0, a5);
    chk("t3_ready_after_retire", 64'(a5), 64'(pop_cyc.exists(1) ? pop_cyc[1] + 1 : -100));
    drain();

    // Zero-length job between two normal ones: in order, error flagged, no array used.
    for (int i = 0; i < N; i++) lat[i] = 20;
    rs0 = run_starts;
    send(8'h21, 8'd5, 8'd6, 1'b0, a);
    send(8'h22, 8'd0, 8'd5, 1'b0, a);
    send(8'h23, 8'd7, 8'd2, 1'b0, a);
    drain();
    chk("t4_array_runs", 64'(run_starts - rs0), 64'd2);

    // Stalled result port must hold the result unchanged.
    for (int i = 0; i < N; i++) lat[i] = 5;
    res_ready = 1'b0;
    send(8'h31, 8'd4, 8'd4, 1'b0, a);
    seen = 1'b0;
    for (b = 0; b < 100 && !seen; b++) begin @(negedge clk); seen = res_valid; end
    chk("t5_valid_seen", 64'(seen), 64'h1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_hold_valid_id_err", 64'({res_valid, res_id, res_err}), 64'({1'b1, 8'h31, 1'b0}));
      chk("t5_hold_val", res_val, fval(8'd4, 8'd4));
    end
    tick();
    res_ready = 1'b1;
    drain();

    // Reset in the middle of work: everything discarded, nothing stale afterwards.
    res_ready = 1'b0;
    lat[0] = 8;
    send(8'h32, 8'd9, 8'd9, 1'b0, a);
    send(8'h33, 8'd0, 8'd1, 1'b0, a);
    repeat (15) tick();
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("t5_rst_res_valid", 64'(res_valid), 64'h0);
    chk("t5_rst_res_val", res_val, 64'h0);
    chk("t5_rst_res_id_err", 64'({res_id, res_err}), 64'h0);
    chk("t5_rst_arr", 64'({arr_reset, arr_busy}), 64'hF0);
    chk("t5_rst_len", 64'(arr_x_len | arr_y_len), 64'h0);
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 30; k++) begin @(negedge clk); if (res_valid) stale++; end
    chk("t5_no_stale", 64'(stale), 64'h0);
    tick();
    send(8'h40, 8'd6, 8'd6, 1'b0, a);
    chk("t5_rr_restart", 64'(arr_x_len[0 +: LW]), 64'd6);
    drain();

`ifdef SCHED_TIMEOUT_EN
    // Array never completes: watchdog retires it with an error after exactly TO RUN cycles.
    for (int i = 0; i < N; i++) lat[i] = 0;
    send(8'h66, 8'd5, 8'd5, 1'b1, a);
    seen = 1'b0;
    for (b = 0; b < 400 && !seen; b++) begin @(negedge clk); seen = res_valid; end
    chk("t6_timeout_seen", 64'(seen), 64'h1);
    chk("t6_timeout_cycles", 64'(cyc - last_run_cyc), 64'(TO));
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
